// File: rtl/sseg_pkg.sv
// Shared types, constants and the priority-search helper for the N-digit
// seven-segment scan driver.
package sseg_pkg;

  localparam int MAX_DIGITS = 16;
  localparam int IDX_W      = 4;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } idx_hit_t;

  // Lowest set bit strictly above idx among the first n bits of mask.
  function automatic idx_hit_t first_set_above(input logic [MAX_DIGITS-1:0] mask,
                                               input logic [IDX_W-1:0]      idx,
                                               input int                    n);
    idx_hit_t hit;
    hit = '0;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < n && k > int'(idx) && mask[k]) begin
        hit.found = 1'b1;
        hit.index = IDX_W'(k);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/sseg_next_idx.sv
// Combinational priority finder: next enabled digit above cur_idx, or the
// first enabled digit from 0 when FROM_ZERO is set.
module sseg_next_idx
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter bit FROM_ZERO = 1'b0
) (
  input  logic [N_DIGITS-1:0] i_mask,
  input  logic [IDX_W-1:0]    i_cur_idx,
  output logic                o_found,
  output logic [IDX_W-1:0]    o_idx
);

  logic [MAX_DIGITS-1:0] w_mask16;
  idx_hit_t              w_hit;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_mask16 = MAX_DIGITS'(i_mask);
    w_hit    = first_set_above(w_mask16, FROM_ZERO ? '0 : i_cur_idx, N_DIGITS);
    if (FROM_ZERO && i_mask[0]) begin
      w_hit.found = 1'b1;
      w_hit.index = '0;
    end
  end

  assign o_found = w_hit.found;
  assign o_idx   = w_hit.index;

endmodule

// File: rtl/sseg_mux_n.sv
// N-digit seven-segment scan driver: masked scan order, blank guard time,
// PWM brightness and per-frame snapshots of the display data.
module sseg_mux_n
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DWELL     = 65536,
  parameter int BLANK_CYC = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   digit_mask,
  input  logic [3:0]            brightness,
  output logic [7:0]            sseg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int SLOT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(DWELL - 1);
  localparam logic [SLOT_W-1:0] BLANK_END  = SLOT_W'(BLANK_CYC);
  localparam logic [3:0]        PWM_LAST   = 4'd14;

  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [3:0]            r_pwm;
  logic [3:0]            r_bright_q;
  logic [IDX_W-1:0]      r_idx;
  logic [N_DIGITS-1:0]   r_mask_q;
  logic [8*N_DIGITS-1:0] r_digits_q;
  logic                  r_load_pending;
  logic                  r_snap_pend;
  logic [7:0]            r_sseg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_start;

  logic                  w_slot_end;
  logic                  w_lit;
  logic [7:0]            w_seg;
  logic [N_DIGITS-1:0]   w_an_lit;
  logic [MAX_DIGITS-1:0] w_mask16;
  logic                  w_above_found;
  logic [IDX_W-1:0]      w_above_idx;
  logic                  w_first_found;
  logic [IDX_W-1:0]      w_first_idx;
  logic [IDX_W-1:0]      w_wrap_idx;

  sseg_next_idx #(.N_DIGITS(N_DIGITS), .FROM_ZERO(1'b0)) u_above (
    .i_mask    (r_mask_q),
    .i_cur_idx (r_idx),
    .o_found   (w_above_found),
    .o_idx     (w_above_idx)
  );

  sseg_next_idx #(.N_DIGITS(N_DIGITS), .FROM_ZERO(1'b1)) u_first (
    .i_mask    (digit_mask),
    .i_cur_idx (r_idx),
    .o_found   (w_first_found),
    .o_idx     (w_first_idx)
  );

  always_comb begin
    w_mask16   = MAX_DIGITS'(r_mask_q);
    w_slot_end = (r_slot_cnt == LAST_SLOT);
    w_lit      = (r_slot_cnt >= BLANK_END) && (r_pwm < r_bright_q) && w_mask16[r_idx];
    w_an_lit   = ~(N_DIGITS'(1) << r_idx);
    w_wrap_idx = w_first_found ? w_first_idx : '0;
    w_seg      = SSEG_BLANK;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_seg = r_digits_q[8*k +: 8];
    end
  end

  // NOTE: the snapshot registers are reset too, so the first frame never shows stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt     <= '0;
      r_pwm          <= '0;
      r_bright_q     <= '0;
      r_idx          <= '0;
      r_mask_q       <= '0;
      r_digits_q     <= {N_DIGITS{SSEG_BLANK}};
      r_load_pending <= 1'b1;
      r_snap_pend    <= 1'b0;
      r_sseg         <= SSEG_BLANK;
      r_an           <= '1;
      r_frame_start  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees the pre-edge state.
      r_slot_cnt    <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
      r_pwm         <= (r_pwm == PWM_LAST) ? '0 : r_pwm + 1'b1;
      r_sseg        <= w_lit ? w_seg : SSEG_BLANK;
      r_an          <= w_lit ? w_an_lit : '1;
      r_frame_start <= r_load_pending | r_snap_pend;
      r_snap_pend   <= 1'b0;
      if (r_slot_cnt == '0) r_bright_q <= brightness;

      if (r_load_pending) begin
        r_load_pending <= 1'b0;
        r_digits_q     <= digits_in;
        r_mask_q       <= digit_mask;
        r_idx          <= w_wrap_idx;
      end else if (w_slot_end) begin
        if (w_above_found) begin
          r_idx <= w_above_idx;
        end else begin
          // Frame wrap: latch a fresh, tear-free copy of the display data.
          r_digits_q  <= digits_in;
          r_mask_q    <= digit_mask;
          r_idx       <= w_wrap_idx;
          r_snap_pend <= 1'b1;
        end
      end
    end
  end

  assign sseg        = r_sseg;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sseg_mux_n.sv
// Directed bench for sseg_mux_n with 4 digits, 8-cycle slots, 2-cycle blank.
module tb_sseg_mux_n;

  logic        clk;
  logic        reset;
  logic [31:0] digits_in;
  logic [3:0]  digit_mask;
  logic [3:0]  brightness;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic        frame_start;

  logic [31:0] pend_digits;
  logic [3:0]  pend_mask;
  logic [3:0]  pend_bright;

  int n_checks = 0;
  int n_errors = 0;

  sseg_mux_n #(.N_DIGITS(4), .DWELL(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .digit_mask  (digit_mask),
    .brightness  (brightness),
    .sseg        (sseg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One 8-cycle slot starting at its first output cycle; optional input poke after cycle poke_at.
  task automatic check_slot(input string tag, input logic exp_fs, input logic [3:0] exp_an,
                            input logic [7:0] exp_seg, input int poke_at);
    logic [12:0] exp_v;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && exp_an != 4'hF) exp_v = {1'b0, exp_an, exp_seg};
      else                          exp_v = {1'b0, 4'hF, 8'hFF};
      if (c == 0) exp_v[12] = exp_fs;
      check($sformatf("%s c%0d", tag, c), {19'd0, frame_start, an, sseg}, {19'd0, exp_v});
      if (c == poke_at) begin
        digits_in  = pend_digits;
        digit_mask = pend_mask;
        brightness = pend_bright;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_frame_start(input string tag);
    @(negedge clk);
    for (int i = 0; i < 100 && !frame_start; i++) @(negedge clk);
    check({tag, " frame_start seen"}, {31'd0, frame_start}, 32'd1);
  endtask

  int cnt_e, cnt_b, cnt_bad, cnt_fs;

  initial begin
    reset       = 1'b1;
    digits_in   = 32'hB0A4F9C0;
    digit_mask  = 4'hF;
    brightness  = 4'd15;
    pend_digits = 32'hB0A4F9C0;
    pend_mask   = 4'hF;
    pend_bright = 4'd15;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("in_reset", {19'd0, frame_start, an, sseg}, {19'd0, 1'b0, 4'hF, 8'hFF});
    end
    reset = 1'b0;
    @(negedge clk);

    // Full scan after reset, then a second frame with a mid-frame data change.
    check_slot("f1_d0", 1'b1, 4'hE, 8'hC0, -1);
    check_slot("f1_d1", 1'b0, 4'hD, 8'hF9, -1);
    check_slot("f1_d2", 1'b0, 4'hB, 8'hA4, -1);
    check_slot("f1_d3", 1'b0, 4'h7, 8'hB0, -1);
    pend_digits = 32'hB0A4F9F9;
    check_slot("f2_d0", 1'b1, 4'hE, 8'hC0, -1);
    check_slot("f2_d1", 1'b0, 4'hD, 8'hF9, 4);
    check_slot("f2_d2", 1'b0, 4'hB, 8'hA4, -1);
    check_slot("f2_d3", 1'b0, 4'h7, 8'hB0, -1);

    // New digit 0 visible; mask change mid-frame does not cut the current frame.
    pend_mask = 4'b0101;
    check_slot("f3_d0", 1'b1, 4'hE, 8'hF9, -1);
    check_slot("f3_d1", 1'b0, 4'hD, 8'hF9, -1);
    check_slot("f3_d2", 1'b0, 4'hB, 8'hA4, 4);
    check_slot("f3_d3", 1'b0, 4'h7, 8'hB0, -1);

    // Two-digit frames of 16 cycles; brightness 0 applied from the next slot.
    pend_bright = 4'd0;
    check_slot("m5_a0", 1'b1, 4'hE, 8'hF9, -1);
    check_slot("m5_a2", 1'b0, 4'hB, 8'hA4, -1);
    check_slot("m5_b0", 1'b1, 4'hE, 8'hF9, -1);
    check_slot("m5_b2", 1'b0, 4'hB, 8'hA4, 4);
    check_slot("dark_0", 1'b1, 4'hF, 8'hFF, -1);
    check_slot("dark_2", 1'b0, 4'hF, 8'hFF, -1);
    check_slot("dark_0b", 1'b1, 4'hF, 8'hFF, -1);

    // Brightness 5 over 15 frames: each lit cycle position meets every pwm phase once.
    brightness = 4'd5;
    wait_frame_start("pwm5");
    cnt_e = 0; cnt_b = 0; cnt_bad = 0; cnt_fs = 0;
    for (int i = 0; i < 240; i++) begin
      if (frame_start) cnt_fs++;
      if (an == 4'hE) begin
        cnt_e++;
        if (sseg != 8'hF9) cnt_bad++;
      end else if (an == 4'hB) begin
        cnt_b++;
        if (sseg != 8'hA4) cnt_bad++;
      end else if (an != 4'hF || sseg != 8'hFF) begin
        cnt_bad++;
      end
      @(negedge clk);
    end
    check("pwm5 lit d0", cnt_e, 32'd30);
    check("pwm5 lit d2", cnt_b, 32'd30);
    check("pwm5 stray", cnt_bad, 32'd0);
    check("pwm5 frames", cnt_fs, 32'd15);

    // Empty mask: blank output, every slot is a frame.
    digit_mask = 4'h0;
    brightness = 4'd15;
    wait_frame_start("mask0");
    check_slot("mask0_s0", 1'b1, 4'hF, 8'hFF, -1);
    check_slot("mask0_s1", 1'b1, 4'hF, 8'hFF, -1);
    check_slot("mask0_s2", 1'b1, 4'hF, 8'hFF, -1);

    // Reset asserted while a digit is lit blanks the pins before the next edge.
    digit_mask = 4'hF;
    wait_frame_start("pre_rst");
    check_slot("pre_rst_d0", 1'b1, 4'hE, 8'hF9, -1);
    repeat (4) @(negedge clk);
    check("lit before reset", {20'd0, an, sseg}, {20'd0, 4'hD, 8'hF9});
    #2 reset = 1'b1;
    #1 check("async blank", {19'd0, frame_start, an, sseg}, {19'd0, 1'b0, 4'hF, 8'hFF});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_slot("post_rst_d0", 1'b1, 4'hE, 8'hF9, -1);
    check_slot("post_rst_d1", 1'b0, 4'hD, 8'hF9, -1);
    check_slot("post_rst_d2", 1'b0, 4'hB, 8'hA4, -1);
    check_slot("post_rst_d3", 1'b0, 4'h7, 8'hB0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
